// File: rtl/inst_mem_pkg.sv
// Shared constants for the instruction-memory arbiter slice.
//   WORD_DEF : default instruction word width in bits
//   PCL_DEF  : default instruction address width in bits
//   REQ_CORE : requester index of the core fetch port
//   REQ_DBG  : requester index of the debug/trace reader port
package inst_mem_pkg;

  localparam int WORD_DEF = 16;
  localparam int PCL_DEF  = 10;

  localparam int REQ_CORE = 0;
  localparam int REQ_DBG  = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a remembered last grant.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   eligible[1:0] : per-requester eligibility this cycle
//   grant[1:0]    : one-hot (or zero) grant, combinational from eligible
// After reset last_grant points at the debug requester, so the core wins
// the first tie.
module rr_arb2
  import inst_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic last_grant;

  // Tie goes to whoever did not win last; a sole eligible requester wins.
  always_comb begin
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = eligible;
    end
  end

  // ---- stage p0 -> p1: remember the winner ----
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant[REQ_CORE]) begin
      last_grant <= 1'b0;
    end else if (grant[REQ_DBG]) begin
      last_grant <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Arbitrates two read requesters (core fetch, debug reader) onto a single
// combinational instruction-memory read port and returns each word through
// a one-deep response register per requester.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid0/1, req_addr0/1   : read requests (address held while stalled)
//   req_ready0/1                : request granted this cycle
//   rsp_valid0/1, rsp_data0/1   : response word, valid one cycle after grant
//   rsp_ready0/1                : requester consumes its response
//   mem_addr                    : address to memory (0 when idle)
//   mem_data                    : combinational memory read data
module inst_mem_arbiter
  import inst_mem_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int PCL  = PCL_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid0,
  input  logic [PCL-1:0]  req_addr0,
  output logic            req_ready0,
  output logic            rsp_valid0,
  output logic [WORD-1:0] rsp_data0,
  input  logic            rsp_ready0,
  input  logic            req_valid1,
  input  logic [PCL-1:0]  req_addr1,
  output logic            req_ready1,
  output logic            rsp_valid1,
  output logic [WORD-1:0] rsp_data1,
  input  logic            rsp_ready1,
  output logic [PCL-1:0]  mem_addr,
  input  logic [WORD-1:0] mem_data
);

  logic [1:0]      eligible_p0;
  logic [1:0]      grant_p0;
  logic [1:0]      vld_p1;
  logic [WORD-1:0] data0_p1;
  logic [WORD-1:0] data1_p1;

  // A requester may be granted only if its response slot is empty or is
  // being drained this very cycle; reset suppresses all grants.
  always_comb begin
    eligible_p0[REQ_CORE] = !rst && req_valid0 && (!vld_p1[REQ_CORE] || rsp_ready0);
    eligible_p0[REQ_DBG]  = !rst && req_valid1 && (!vld_p1[REQ_DBG]  || rsp_ready1);
  end

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible_p0),
    .grant    (grant_p0)
  );

  always_comb begin
    mem_addr = '0;
    if (grant_p0[REQ_CORE]) begin
      mem_addr = req_addr0;
    end else if (grant_p0[REQ_DBG]) begin
      mem_addr = req_addr1;
    end
  end

  assign req_ready0 = grant_p0[REQ_CORE];
  assign req_ready1 = grant_p0[REQ_DBG];

  // ---- stage p0 -> p1: capture memory word into the granted slot ----
  // A new grant wins over a drain so back-to-back reads keep the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 2'b00;
      data0_p1 <= '0;
      data1_p1 <= '0;
    end else begin
      if (grant_p0[REQ_CORE]) begin
        vld_p1[REQ_CORE] <= 1'b1;
        data0_p1         <= mem_data;
      end else if (rsp_ready0) begin
        vld_p1[REQ_CORE] <= 1'b0;
      end
      if (grant_p0[REQ_DBG]) begin
        vld_p1[REQ_DBG] <= 1'b1;
        data1_p1        <= mem_data;
      end else if (rsp_ready1) begin
        vld_p1[REQ_DBG] <= 1'b0;
      end
    end
  end

  assign rsp_valid0 = vld_p1[REQ_CORE];
  assign rsp_valid1 = vld_p1[REQ_DBG];
  assign rsp_data0  = data0_p1;
  assign rsp_data1  = data1_p1;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed bench for inst_mem_arbiter: a behavioural model checked every
// cycle plus literal expectations for the scenario outcomes.
module tb_inst_mem_arbiter;

  localparam int WORD = 16;
  localparam int PCL  = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid0, req_valid1;
  logic [PCL-1:0]  req_addr0, req_addr1;
  logic            req_ready0, req_ready1;
  logic            rsp_valid0, rsp_valid1;
  logic [WORD-1:0] rsp_data0, rsp_data1;
  logic            rsp_ready0, rsp_ready1;
  logic [PCL-1:0]  mem_addr;
  logic [WORD-1:0] mem_data;

  logic [WORD-1:0] mem [0:(1<<PCL)-1];

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  inst_mem_arbiter #(.WORD(WORD), .PCL(PCL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid0 (req_valid0),
    .req_addr0  (req_addr0),
    .req_ready0 (req_ready0),
    .rsp_valid0 (rsp_valid0),
    .rsp_data0  (rsp_data0),
    .rsp_ready0 (rsp_ready0),
    .req_valid1 (req_valid1),
    .req_addr1  (req_addr1),
    .req_ready1 (req_ready1),
    .rsp_valid1 (rsp_valid1),
    .rsp_data1  (rsp_data1),
    .rsp_ready1 (rsp_ready1),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_valid [2];
  logic [WORD-1:0] m_data  [2];
  int              m_last = 1;

  // Returns granted requester index, or -1 for no grant.
  function automatic int model_grant();
    bit el [2];
    el[0] = !rst && req_valid0 && (!m_valid[0] || rsp_ready0);
    el[1] = !rst && req_valid1 && (!m_valid[1] || rsp_ready1);
    if (el[0] && el[1]) return (m_last == 0) ? 1 : 0;
    if (el[0]) return 0;
    if (el[1]) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    bit rdy [2];
    logic [PCL-1:0] a [2];
    g = model_grant();
    rdy[0] = rsp_ready0; rdy[1] = rsp_ready1;
    a[0] = req_addr0;    a[1] = req_addr1;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_valid[i] = 1'b0;
        m_data[i]  = '0;
      end
      m_last = 1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (g == i) begin
          m_valid[i] = 1'b1;
          m_data[i]  = mem[a[i]];
        end else if (rdy[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (g >= 0) m_last = g;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [PCL-1:0] ea;
    if (chk_en) begin
      g  = model_grant();
      ea = (g == 0) ? req_addr0 : (g == 1) ? req_addr1 : '0;
      check("m_req_ready0", req_ready0, (g == 0));
      check("m_req_ready1", req_ready1, (g == 1));
      check("m_mem_addr",   mem_addr,   ea);
      check("m_rsp_valid0", rsp_valid0, m_valid[0]);
      check("m_rsp_valid1", rsp_valid1, m_valid[1]);
      check("m_rsp_data0",  rsp_data0,  m_data[0]);
      check("m_rsp_data1",  rsp_data1,  m_data[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input int a0, input bit r0,
                       input bit v1, input int a1, input bit r1);
    req_valid0 = v0; req_addr0 = a0[PCL-1:0]; rsp_ready0 = r0;
    req_valid1 = v1; req_addr1 = a1[PCL-1:0]; rsp_ready1 = r1;
  endtask

  initial begin
    for (int i = 0; i < (1 << PCL); i++) mem[i] = 16'hA000 + i[15:0];
    mem[5] = 16'h1234;
    mem[9] = 16'hBEEF;

    rst = 1'b1;
    drive(1, 7, 0, 1, 8, 0);
    next_cycle();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready0", req_ready0, 0);
    check("rst_ready1", req_ready1, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_valid0", rsp_valid0, 0);
    check("rst_valid1", rsp_valid1, 0);
    check("rst_data0", rsp_data0, 0);
    check("rst_data1", rsp_data1, 0);
    next_cycle();

    // Single fetch of address 5
    rst = 1'b0;
    drive(1, 5, 1, 0, 0, 0);
    @(negedge clk);
    check("s1_ready0", req_ready0, 1);
    check("s1_mem_addr", mem_addr, 5);
    next_cycle();
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("s1_valid0", rsp_valid0, 1);
    check("s1_data0", rsp_data0, 16'h1234);
    next_cycle();
    @(negedge clk);
    check("s1_drained", rsp_valid0, 0);
    next_cycle();

    // Back-to-back stream, addresses 0..3
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) drive(1, k, 1, 0, 0, 0);
      else       drive(0, 0, 1, 0, 0, 0);
      @(negedge clk);
      if (k > 0) begin
        check("s2_valid0", rsp_valid0, 1);
        check("s2_data0", rsp_data0, 16'hA000 + k - 1);
      end
      if (k < 4) check("s2_ready0", req_ready0, 1);
      next_cycle();
    end

    // Both streaming after reset: grants alternate starting with 0
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 1);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(1, 1, 1, 1, 2, 1);
      @(negedge clk);
      check("s3_ready0", req_ready0, (c % 2 == 0));
      check("s3_ready1", req_ready1, (c % 2 == 1));
      check("s3_valid0", rsp_valid0, (c % 2 == 1));
      check("s3_valid1", rsp_valid1, (c % 2 == 0) && (c > 0));
      next_cycle();
    end

    // Reset right after a grant to requester 0
    drive(0, 0, 1, 0, 0, 1);
    next_cycle();
    drive(1, 3, 0, 0, 0, 0);
    @(negedge clk);
    check("s4_grant0", req_ready0, 1);
    next_cycle();
    rst = 1'b1;
    drive(1, 3, 0, 1, 4, 0);
    @(negedge clk);
    check("s4_rst_ready0", req_ready0, 0);
    check("s4_rst_ready1", req_ready1, 0);
    check("s4_rst_addr", mem_addr, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("s4_valid0_cleared", rsp_valid0, 0);
    check("s4_tie_to0", req_ready0, 1);
    check("s4_tie_not1", req_ready1, 0);
    next_cycle();

    // Stalled debug response must not block core stream
    drive(0, 0, 1, 0, 0, 1);
    next_cycle();
    drive(0, 0, 1, 1, 9, 0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1, k, 1, 1, 9, 0);
      @(negedge clk);
      check("s5_ready1", req_ready1, 0);
      check("s5_ready0", req_ready0, 1);
      check("s5_addr", mem_addr, k);
      check("s5_valid1", rsp_valid1, 1);
      check("s5_data1", rsp_data1, 16'hBEEF);
      next_cycle();
    end

    // Idle: no requests, responses held
    for (int k = 0; k < 2; k++) begin
      drive(0, 6, 0, 0, 6, 0);
      @(negedge clk);
      check("s6_addr", mem_addr, 0);
      check("s6_ready0", req_ready0, 0);
      check("s6_ready1", req_ready1, 0);
      check("s6_valid0", rsp_valid0, 1);
      check("s6_valid1", rsp_valid1, 1);
      check("s6_data0", rsp_data0, 16'hA002);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 1);
    next_cycle();
    @(negedge clk);
    check("s6_drain1", rsp_valid1, 0);
    check("s6_keep0", rsp_valid0, 1);
    next_cycle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
